// File: rtl/axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen
//
// AXI-Stream packet source producing 64-bit beats of a closed-form byte
// pattern so a downstream checker can verify every byte without storage.
// Byte k of beat b in packet p is (p[7:0] + 8*b + k) mod 256.
//
// Ports
//   CLK            : single clock, rising edge
//   RESET          : asynchronous, active-high reset
//   START          : one-cycle run request, sampled only while idle
//   STOP           : ends the run after the packet in flight (sticky)
//   PKT_LEN        : beats per packet (0 behaves as 1)
//   PKT_COUNT      : packets per run (0 = continuous until STOP)
//   GAP            : TVALID-low cycles between packets
//   BUSY           : run in progress
//   DONE           : one-cycle pulse when a run ends
//   PKTS_SENT      : packets completed in the current/last run
//   M_AXIS_*       : AXI-Stream master (TDATA, TVALID, TREADY, TLAST)
// -----------------------------------------------------------------------------
module axis_pattern_gen #(
    parameter int LEN_WIDTH = 16,
    parameter int CNT_WIDTH = 16,
    parameter int GAP_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [LEN_WIDTH-1:0] PKT_LEN,
    input  logic [CNT_WIDTH-1:0] PKT_COUNT,
    input  logic [GAP_WIDTH-1:0] GAP,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CNT_WIDTH-1:0] PKTS_SENT,
    output logic [63:0]          M_AXIS_TDATA,
    output logic                 M_AXIS_TVALID,
    input  logic                 M_AXIS_TREADY,
    output logic                 M_AXIS_TLAST
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    // Run parameters latched at START; they only matter while a run is active
    logic [LEN_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_count;
    logic [GAP_WIDTH-1:0] r_gap;

    logic [LEN_WIDTH-1:0] r_beat;
    logic [7:0]           r_pkt;
    logic [CNT_WIDTH-1:0] r_pkts_sent;
    logic [GAP_WIDTH-1:0] r_gap_cnt;
    logic                 r_stop;
    logic                 r_done;

    logic                 w_valid;
    logic                 w_hs;
    logic                 w_last_beat;
    logic                 w_pkt_end;
    logic                 w_finish;
    logic                 w_stop_seen;
    logic [LEN_WIDTH-1:0] w_len_m1;
    logic [CNT_WIDTH-1:0] w_sent_inc;

    function automatic logic [63:0] f_pattern(input logic [7:0] p, input logic [4:0] b);
        logic [63:0] d;
        logic [7:0]  base;
        base = p + {b, 3'b000};
        d    = '0;
        for (int k = 0; k < 8; k++) begin
            d[8*k +: 8] = base + 8'(k);
        end
        return d;
    endfunction

    assign w_valid     = (r_state == S_SEND);
    assign w_len_m1    = r_len - 1'b1;
    assign w_last_beat = (r_beat == w_len_m1);
    assign w_sent_inc  = r_pkts_sent + 1'b1;
    // A STOP arriving in the same cycle as the final handshake still counts
    assign w_stop_seen = r_stop | STOP;

    // Next-state and transfer decode
    always_comb begin
        w_next_state = r_state;
        w_hs         = 1'b0;
        w_pkt_end    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_hs = M_AXIS_TREADY;
                if (w_hs && w_last_beat) begin
                    w_pkt_end = 1'b1;
                    if (w_stop_seen || ((r_count != '0) && (w_sent_inc == r_count))) begin
                        w_finish     = 1'b1;
                        w_next_state = S_IDLE;
                    end else if (r_gap != '0) begin
                        w_next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_stop_seen) begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_next_state = S_SEND;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Stage boundary: run control and counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_beat      <= '0;
            r_pkt       <= '0;
            r_pkts_sent <= '0;
            r_gap_cnt   <= '0;
            r_stop      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_beat      <= '0;
                        r_pkt       <= '0;
                        r_pkts_sent <= '0;
                        r_stop      <= STOP;
                    end
                end
                S_SEND: begin
                    r_stop <= w_stop_seen;
                    if (w_hs) begin
                        if (w_pkt_end) begin
                            r_beat      <= '0;
                            r_pkt       <= r_pkt + 1'b1;
                            r_pkts_sent <= w_sent_inc;
                            // Counts down to zero so the gap lasts exactly GAP cycles
                            r_gap_cnt   <= r_gap - 1'b1;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    r_stop    <= w_stop_seen;
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: begin
                    r_stop <= r_stop;
                end
            endcase
        end
    end

    // Stage boundary: parameter latch (data only, no reset needed)
    always_ff @(posedge CLK) begin
        if ((r_state == S_IDLE) && START) begin
            r_len   <= (PKT_LEN == '0) ? {{(LEN_WIDTH-1){1'b0}}, 1'b1} : PKT_LEN;
            r_count <= PKT_COUNT;
            r_gap   <= GAP;
        end
    end

    // Outputs derive from registered state, so reset clears them immediately;
    // TDATA is gated to zero whenever no beat is offered.
    assign M_AXIS_TVALID = w_valid;
    assign M_AXIS_TLAST  = w_valid & w_last_beat;
    assign M_AXIS_TDATA  = w_valid ? f_pattern(r_pkt, r_beat[4:0]) : 64'd0;
    assign BUSY          = (r_state != S_IDLE);
    assign DONE          = r_done;
    assign PKTS_SENT     = r_pkts_sent;

endmodule

// File: tb/tb_axis_pattern_gen.sv
module tb_axis_pattern_gen;

    localparam int LW = 16;
    localparam int CW = 16;
    localparam int GW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          START;
    logic          STOP;
    logic [LW-1:0] PKT_LEN;
    logic [CW-1:0] PKT_COUNT;
    logic [GW-1:0] GAP;
    logic          BUSY;
    logic          DONE;
    logic [CW-1:0] PKTS_SENT;
    logic [63:0]   M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic          M_AXIS_TLAST;

    axis_pattern_gen #(.LEN_WIDTH(LW), .CNT_WIDTH(CW), .GAP_WIDTH(GW)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .START         (START),
        .STOP          (STOP),
        .PKT_LEN       (PKT_LEN),
        .PKT_COUNT     (PKT_COUNT),
        .GAP           (GAP),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .PKTS_SENT     (PKTS_SENT),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: byte k of beat b in packet p is (p + 8b + k) mod 256
    function automatic logic [63:0] model_beat(input int p, input int b);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) begin
            d[8*k +: 8] = 8'((p + 8 * b + k) % 256);
        end
        return d;
    endfunction

    // ---------------- TREADY driver ----------------
    int rmode = 0;
    int tick  = 0;
    always @(posedge CLK) begin
        #1;
        tick++;
        case (rmode)
            0:       M_AXIS_TREADY = 1'b1;
            1:       M_AXIS_TREADY = ((tick % 4) == 0) || ((tick % 4) == 3);
            2:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
            default: M_AXIS_TREADY = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    bit          mon_en     = 0;
    int          hs_count   = 0;
    bit          after_last = 0;
    int          lowcnt     = 0;
    int          exp_gap    = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    always @(negedge CLK) begin
        if (mon_en) begin
            beat_t e;
            if (prev_stall) begin
                check("stall_tdata", M_AXIS_TDATA, prev_data);
                check("stall_tlast", 64'(M_AXIS_TLAST), 64'(prev_last));
            end
            if (DONE) after_last = 0;
            if (M_AXIS_TVALID) begin
                if (after_last) begin
                    check("gap_len", 64'(lowcnt), 64'(exp_gap));
                    after_last = 0;
                end
                if (M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", M_AXIS_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", M_AXIS_TDATA, e.data);
                        check("tlast", 64'(M_AXIS_TLAST), 64'(e.last));
                    end
                    hs_count++;
                    if (M_AXIS_TLAST) begin
                        after_last = 1;
                        lowcnt     = 0;
                    end
                end
            end else if (after_last && BUSY) begin
                lowcnt++;
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_data  = M_AXIS_TDATA;
            prev_last  = M_AXIS_TLAST;
        end else begin
            prev_stall = 0;
        end
    end

    // ---------------- stimulus ----------------
    // stop_hs > 0: pulse STOP once when that many beats have transferred
    task automatic do_run(input int len, input int cnt, input int gap, input int mode,
                          input int stop_hs, input bit start_stop, input bit extra_start);
        int eff_len;
        int npk;
        bit done_seen;
        bit stop_sent;
        eff_len = (len == 0) ? 1 : len;
        if (cnt != 0)                                   npk = cnt;
        else if (start_stop)                            npk = 1;
        else if ((stop_hs % eff_len == 0) && (gap > 0)) npk = stop_hs / eff_len;
        else                                            npk = stop_hs / eff_len + 1;
        for (int p = 0; p < npk; p++) begin
            for (int b = 0; b < eff_len; b++) begin
                beat_t e;
                e.data = model_beat(p, b);
                e.last = (b == eff_len - 1);
                exp_q.push_back(e);
            end
        end
        exp_gap    = gap;
        hs_count   = 0;
        after_last = 0;
        rmode      = mode;
        mon_en     = 1;

        @(posedge CLK); #1;
        PKT_LEN   = LW'(len);
        PKT_COUNT = CW'(cnt);
        GAP       = GW'(gap);
        START     = 1'b1;
        STOP      = start_stop;
        @(posedge CLK); #1;
        START = 1'b0;
        STOP  = 1'b0;
        check("busy_after_start", 64'(BUSY), 64'd1);
        check("tvalid_latency", 64'(M_AXIS_TVALID), 64'd1);

        done_seen = 0;
        stop_sent = 0;
        for (int c = 0; c < 5000 && !done_seen; c++) begin
            START = 1'b0;
            STOP  = 1'b0;
            if (stop_hs > 0 && !stop_sent && hs_count == stop_hs) begin
                STOP      = 1'b1;
                stop_sent = 1;
            end
            if (extra_start && c == 2) begin
                START   = 1'b1;
                PKT_LEN = LW'(7);
            end
            @(negedge CLK);
            if (DONE) done_seen = 1;
            else begin
                @(posedge CLK); #1;
            end
        end
        START = 1'b0;
        STOP  = 1'b0;

        if (!done_seen) begin
            checks++;
            $display("FAIL done_timeout: DONE=%0d, expected a DONE pulse within 5000 cycles", DONE);
            exp_q.delete();
        end else begin
            check("pkts_sent", 64'(PKTS_SENT), 64'(CW'(npk)));
            check("busy_at_done", 64'(BUSY), 64'd0);
            check("tvalid_at_done", 64'(M_AXIS_TVALID), 64'd0);
            check("all_beats_seen", 64'(exp_q.size()), 64'd0);
            @(negedge CLK);
            check("done_one_cycle", 64'(DONE), 64'd0);
            check("tvalid_after_done", 64'(M_AXIS_TVALID), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        RESET         = 1'b1;
        START         = 1'b0;
        STOP          = 1'b0;
        PKT_LEN       = '0;
        PKT_COUNT     = '0;
        GAP           = '0;
        M_AXIS_TREADY = 1'b0;
        #12;
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("rst_tdata", M_AXIS_TDATA, 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_pkts_sent", 64'(PKTS_SENT), 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);

        // single packet
        do_run(4, 1, 0, 0, 0, 0, 0);
        // back-to-back packets
        do_run(2, 3, 0, 0, 0, 0, 0);
        // gap with 1,0,0,1 backpressure
        do_run(3, 2, 5, 1, 0, 0, 0);
        // continuous, STOP on beat 2 of packet 4
        do_run(8, 0, 0, 0, 34, 0, 0);
        // PKT_LEN=0 and packet-seed wrap past 255
        do_run(0, 300, 0, 0, 0, 0, 0);
        // STOP while in the inter-packet gap
        do_run(2, 0, 6, 2, 4, 0, 0);
        // STOP in idle is ignored
        @(posedge CLK); #1;
        STOP = 1'b1;
        @(posedge CLK); #1;
        STOP = 1'b0;
        do_run(2, 2, 1, 0, 0, 0, 0);
        // START and STOP in the same idle cycle
        do_run(3, 0, 2, 0, 0, 1, 0);
        // START while busy is ignored
        do_run(5, 3, 2, 2, 0, 0, 1);
        // randomized runs
        for (int i = 0; i < 6; i++) begin
            do_run($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 3), 2, 0, 0, 0);
        end

        // asynchronous reset mid-packet under backpressure
        mon_en = 0;
        rmode  = 3;
        @(posedge CLK); #1;
        PKT_LEN   = LW'(4);
        PKT_COUNT = CW'(1);
        GAP       = '0;
        START     = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("pre_reset_tvalid", 64'(M_AXIS_TVALID), 64'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("async_rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("async_rst_tdata", M_AXIS_TDATA, 64'd0);
        check("async_rst_busy", 64'(BUSY), 64'd0);
        check("async_rst_pkts", 64'(PKTS_SENT), 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        do_run(3, 1, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
